// File: rtl/regfile_alu_seq.sv
// -----------------------------------------------------------------------------
// regfile_alu_seq
//
// Instruction sequencer plus 4-bit ALU that sits directly in front of a
// 4 x 4-bit register file with two combinational read ports and one write port.
// One register-to-register instruction is processed at a time through an
// IDLE -> EXEC -> WB sequence, so throughput is one instruction per 3 cycles.
//
// Instruction word: [7:6] op, [5:4] rd, [3:2] ra, [1:0] rb
//   op 00 ADD   : {carry, r} = a + b
//   op 01 SUB   : r = a - b (mod 16), carry = borrow (a < b)
//   op 10 AND   : r = a & b,           carry = 0
//   op 11 LOADI : r = instr[3:0],      carry = 0
//   zero = (r == 0) for every op
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   instr, instr_valid  instruction word and its valid strobe
//   instr_ready         high only in IDLE; depends on state alone
//   raddr_a, raddr_b    register file read addresses (registered ra / rb)
//   dout_a, dout_b      register file read data (combinational from raddr_*)
//   waddr, din, wren    register file write port, active in WB only
//   carry, zero         flags of the last completed instruction
//   done                one-cycle pulse in the WB cycle
// -----------------------------------------------------------------------------
module regfile_alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  output logic [1:0] raddr_a,
  output logic [1:0] raddr_b,
  input  logic [3:0] dout_a,
  input  logic [3:0] dout_b,
  output logic [1:0] waddr,
  output logic [3:0] din,
  output logic       wren,
  output logic       carry,
  output logic       zero,
  output logic       done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_LOADI = 2'b11;

  logic [1:0] state_q;
  logic [1:0] op_q;
  logic [1:0] rd_q;
  logic [1:0] ra_q;
  logic [1:0] rb_q;
  logic [3:0] result_q;
  logic       carry_nxt_q;
  logic       zero_nxt_q;

  logic [3:0] alu_res;
  logic       alu_carry;

  // ALU: the only combinational path from dout_a/dout_b, used in EXEC.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_res   = 4'h0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD:   {alu_carry, alu_res} = {1'b0, dout_a} + {1'b0, dout_b};
      // Bit 4 of the 5-bit difference is the borrow (set iff a < b unsigned).
      OP_SUB:   {alu_carry, alu_res} = {1'b0, dout_a} - {1'b0, dout_b};
      OP_AND:   alu_res = dout_a & dout_b;
      // LOADI reuses the ra/rb fields as the 4-bit immediate.
      OP_LOADI: alu_res = {ra_q, rb_q};
      default:  alu_res = 4'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      rd_q        <= 2'b00;
      ra_q        <= 2'b00;
      rb_q        <= 2'b00;
      result_q    <= 4'h0;
      carry_nxt_q <= 1'b0;
      zero_nxt_q  <= 1'b0;
      carry       <= 1'b0;
      zero        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q    <= instr[7:6];
            rd_q    <= instr[5:4];
            ra_q    <= instr[3:2];
            rb_q    <= instr[1:0];
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Operands are captured here, before the write, so rd == ra/rb is safe.
          result_q    <= alu_res;
          carry_nxt_q <= alu_carry;
          zero_nxt_q  <= (alu_res == 4'h0);
          state_q     <= ST_WB;
        end
        ST_WB: begin
          // Flags commit on the same edge the register file stores din.
          carry   <= carry_nxt_q;
          zero    <= zero_nxt_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state and registers only; an async reset forces
  // state_q to IDLE, which drops wren/done immediately.
  assign instr_ready = (state_q == ST_IDLE);
  assign raddr_a     = ra_q;
  assign raddr_b     = rb_q;
  assign wren        = (state_q == ST_WB);
  assign done        = (state_q == ST_WB);
  assign waddr       = (state_q == ST_WB) ? rd_q     : 2'b00;
  assign din         = (state_q == ST_WB) ? result_q : 4'h0;

endmodule

// File: tb/tb_regfile_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_regfile_alu_seq
//
// Directed test for regfile_alu_seq with a behavioural 4 x 4-bit register file
// attached. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_alu_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;
  logic [3:0] dout_a;
  logic [3:0] dout_b;
  logic [1:0] waddr;
  logic [3:0] din;
  logic       wren;
  logic       carry;
  logic       zero;
  logic       done;

  int n_checks = 0;
  int n_fails  = 0;
  int n_writes = 0;

  logic [3:0] rf [4];

  regfile_alu_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .raddr_a     (raddr_a),
    .raddr_b     (raddr_b),
    .dout_a      (dout_a),
    .dout_b      (dout_b),
    .waddr       (waddr),
    .din         (din),
    .wren        (wren),
    .carry       (carry),
    .zero        (zero),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational reads, write on rising edge.
  assign dout_a = rf[raddr_a];
  assign dout_b = rf[raddr_b];

  always @(posedge clk) begin
    if (wren) begin
      rf[waddr] <= din;
      n_writes  <= n_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, instr_ready, 1);
    check({tag, ".wren"},  wren,        0);
    check({tag, ".done"},  done,        0);
    check({tag, ".waddr"}, waddr,       0);
    check({tag, ".din"},   din,         0);
    check({tag, ".raddr"}, {raddr_a, raddr_b}, 0);
    check({tag, ".carry"}, carry,       0);
    check({tag, ".zero"},  zero,        0);
  endtask

  // Runs one instruction through accept / EXEC / WB / back to IDLE.
  // junk_en drives a different valid instruction during EXEC and WB.
  task automatic issue(input string tag, input logic [7:0] ins,
                       input bit junk_en, input logic [7:0] junk,
                       input bit chk_rd, input logic [1:0] ea, input logic [1:0] eb,
                       input logic [1:0] ewa, input logic [3:0] ed,
                       input logic ec, input logic ez);
    int w0;
    @(negedge clk);
    check({tag, ".ready_idle"}, instr_ready, 1);
    instr       = ins;
    instr_valid = 1'b1;
    w0          = n_writes;
    @(negedge clk);                          // EXEC
    instr       = junk;
    instr_valid = junk_en;
    check({tag, ".ready_exec"}, instr_ready, 0);
    check({tag, ".wren_exec"},  wren,        0);
    if (chk_rd) check({tag, ".raddr"}, {raddr_a, raddr_b}, {ea, eb});
    @(negedge clk);                          // WB
    check({tag, ".ready_wb"}, instr_ready, 0);
    check({tag, ".wren_wb"},  wren,        1);
    check({tag, ".done_wb"},  done,        1);
    check({tag, ".waddr"},    waddr,       ewa);
    check({tag, ".din"},      din,         ed);
    @(negedge clk);                          // back in IDLE
    instr_valid = 1'b0;
    check({tag, ".ready_ret"}, instr_ready, 1);
    check({tag, ".done_ret"},  done,        0);
    check({tag, ".carry"},     carry,       ec);
    check({tag, ".zero"},      zero,        ez);
    check({tag, ".writes"},    n_writes - w0, 1);
    check({tag, ".rf"},        rf[ewa],     ed);
  endtask

  initial begin
    int w0;
    rst_n       = 1'b0;
    instr       = 8'h00;
    instr_valid = 1'b0;
    #2;
    check_reset_outputs("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release.ready", instr_ready, 1);

    //   tag          instr  junk        rd   ra    rb    wa    din   c     z
    issue("loadi_r1_5", 8'hD5, 0, 8'h00, 0, 2'd0, 2'd0, 2'd1, 4'h5, 1'b0, 1'b0);
    issue("loadi_r2_3", 8'hE3, 0, 8'h00, 0, 2'd0, 2'd0, 2'd2, 4'h3, 1'b0, 1'b0);
    issue("add_r3",     8'h36, 0, 8'h00, 1, 2'd1, 2'd2, 2'd3, 4'h8, 1'b0, 1'b0);
    issue("loadi_r1_f", 8'hDF, 0, 8'h00, 0, 2'd0, 2'd0, 2'd1, 4'hF, 1'b0, 1'b0);
    issue("loadi_r2_1", 8'hE1, 0, 8'h00, 0, 2'd0, 2'd0, 2'd2, 4'h1, 1'b0, 1'b0);
    issue("add_ovf",    8'h06, 0, 8'h00, 1, 2'd1, 2'd2, 2'd0, 4'h0, 1'b1, 1'b1);
    issue("loadi_r1_5b",8'hD5, 0, 8'h00, 0, 2'd0, 2'd0, 2'd1, 4'h5, 1'b0, 1'b0);
    issue("loadi_r2_3b",8'hE3, 0, 8'h00, 0, 2'd0, 2'd0, 2'd2, 4'h3, 1'b0, 1'b0);
    issue("sub_borrow", 8'h49, 0, 8'h00, 1, 2'd2, 2'd1, 2'd0, 4'hE, 1'b1, 1'b0);
    issue("and_r3",     8'hB6, 0, 8'h00, 1, 2'd1, 2'd2, 2'd3, 4'h1, 1'b0, 1'b0);
    // Junk LOADI r3,7 held valid during EXEC/WB must be ignored.
    issue("loadi_junk", 8'hC0, 1, 8'hF7, 0, 2'd0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b1);
    check("junk.r3_kept", rf[3], 4'h1);
    check("junk.zero_hold", zero, 1);

    // Reset during WB of LOADI r3,9: wren must drop at once, no write.
    @(negedge clk);
    instr       = 8'hF9;
    instr_valid = 1'b1;
    w0          = n_writes;
    @(negedge clk);                          // EXEC
    instr_valid = 1'b0;
    @(negedge clk);                          // WB
    check("wbrst.wren_before", wren, 1);
    check("wbrst.din_before",  din,  4'h9);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("wbrst");
    @(negedge clk);
    rst_n = 1'b1;
    check("wbrst.no_write", n_writes - w0, 0);
    check("wbrst.r3_kept",  rf[3], 4'h1);

    // r0 = 0, so ADD r1,r3,r0 writes back r3 unchanged.
    issue("add_r3_r0", 8'h1C, 0, 8'h00, 1, 2'd3, 2'd0, 2'd1, 4'h1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end of test");
    $fatal(1, "timeout");
  end

endmodule
